// File: rtl/datapath_pkg.sv
// datapath_pkg: shared machine-code layout and ALU opcodes for the control unit and datapath.
package datapath_pkg;
   localparam int MC_W = 14;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;
   typedef struct packed {
      logic       rf_src_sel;
      logic [2:0] raddr1;
      logic [2:0] raddr2;
      logic [2:0] waddr;
      logic       wr_en;
      alu_op_e    alu_op;
      logic       out_load;
   } machine_code_t;
endpackage

// File: rtl/alu_datapath_if.sv
// alu_datapath_if: machine-code bus from the control unit and the datapath's result/flag outputs.
interface alu_datapath_if import datapath_pkg::*; #(parameter int DATA_W = 8);
   machine_code_t     machineCode;
   logic [DATA_W-1:0] outPort;
   logic              zero_flag;
   logic              carry_flag;
   modport master (output machineCode, input outPort, zero_flag, carry_flag);
   modport slave (input machineCode, output outPort, zero_flag, carry_flag);
endinterface

// File: rtl/alu_datapath_register_file.sv
// register_file: 8 x DATA_W registers, two async read ports, one sync write port, R0 reads as zero.
module register_file #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        raddr1,
   input  logic [2:0]        raddr2,
   input  logic [2:0]        waddr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] regs [NUM_REGS];
   always_ff @(posedge clk) begin
      if (!reset)
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (wr_en && waddr != 3'd0)
         regs[waddr] <= wdata;
   end
   assign rdata1 = (raddr1 == 3'd0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == 3'd0) ? '0 : regs[raddr2];
endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: register file, 4-op ALU, write-source mux and registered output port.
// Define ALU_FLAGS_EN to build the zero/carry flag registers; otherwise the flags are tied low.
module alu_datapath import datapath_pkg::*; #(
   parameter int DATA_W = 8
) (
   input logic           clk,
   input logic           reset,
   alu_datapath_if.slave bus
);
   machine_code_t     mc;
   logic [DATA_W-1:0] rdata1, rdata2, result, wdata, out_q;
   assign mc = bus.machineCode;
   register_file #(.DATA_W(DATA_W), .NUM_REGS(8)) u_rf (
      .clk    (clk),
      .reset  (reset),
      .raddr1 (mc.raddr1),
      .raddr2 (mc.raddr2),
      .waddr  (mc.waddr),
      .wr_en  (mc.wr_en),
      .wdata  (wdata),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );
   always_comb begin
      result = mc.alu_op == ALU_ADD ? rdata1 + rdata2 :
               mc.alu_op == ALU_SUB ? rdata1 - rdata2 :
               mc.alu_op == ALU_AND ? rdata1 & rdata2 : rdata1 | rdata2;
      wdata  = mc.rf_src_sel ? DATA_W'(1) : result;
   end
   always_ff @(posedge clk) begin
      if (!reset)
         out_q <= '0;
      else if (mc.out_load)
         out_q <= rdata1;
   end
   assign bus.outPort = out_q;
`ifdef ALU_FLAGS_EN
   logic [DATA_W:0] sum;
   logic            carry, zero_q, carry_q;
   always_comb begin
      sum   = {1'b0, rdata1} + {1'b0, rdata2};
      carry = mc.alu_op == ALU_ADD ? sum[DATA_W] :
              mc.alu_op == ALU_SUB ? (rdata1 < rdata2) : 1'b0;
   end
   // Only ALU results written to a real register update the flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (mc.wr_en && mc.waddr != 3'd0 && !mc.rf_src_sel) begin
         zero_q  <= (result == '0);
         carry_q <= carry;
      end
   end
   assign bus.zero_flag  = zero_q;
   assign bus.carry_flag = carry_q;
`else
   assign bus.zero_flag  = 1'b0;
   assign bus.carry_flag = 1'b0;
`endif
endmodule
